// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC cosine custom instruction.
// Fixed-point constants are kept at 30 fractional bits and rescaled to the
// instance's fractional width by rescale_q30().
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREP   = 2'd1,
    ROTATE = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_COS   = 2'd0,
    MODE_ADD   = 2'd1,
    MODE_ACC   = 2'd2,
    MODE_RDCLR = 2'd3
  } mode_t;

  // Reciprocal CORDIC gain 0.607252935, and pi, pi/2, all at 30 fractional bits.
  localparam logic signed [63:0] K_Q30    = 64'sd652032875;
  localparam logic signed [63:0] PI_Q30   = 64'sd3373259426;
  localparam logic signed [63:0] PI_2_Q30 = 64'sd1686629713;

  // atan(2^-i) at 30 fractional bits, i = 0..23.
  function automatic logic signed [63:0] atan_q30(input logic [4:0] i);
    case (i)
      5'd0:    atan_q30 = 64'sh3243F6A8;
      5'd1:    atan_q30 = 64'sh1DAC6705;
      5'd2:    atan_q30 = 64'sh0FADBAFC;
      5'd3:    atan_q30 = 64'sh07F56EA6;
      5'd4:    atan_q30 = 64'sh03FEAB76;
      5'd5:    atan_q30 = 64'sh01FFD55B;
      5'd6:    atan_q30 = 64'sh00FFFAAA;
      5'd7:    atan_q30 = 64'sh007FFF55;
      5'd8:    atan_q30 = 64'sh003FFFEA;
      5'd9:    atan_q30 = 64'sh001FFFFD;
      5'd10:   atan_q30 = 64'sh000FFFFF;
      5'd11:   atan_q30 = 64'sh0007FFFF;
      5'd12:   atan_q30 = 64'sh0003FFFF;
      5'd13:   atan_q30 = 64'sh0001FFFF;
      5'd14:   atan_q30 = 64'sh0000FFFF;
      5'd15:   atan_q30 = 64'sh00007FFF;
      5'd16:   atan_q30 = 64'sh00003FFF;
      5'd17:   atan_q30 = 64'sh00001FFF;
      5'd18:   atan_q30 = 64'sh00000FFF;
      5'd19:   atan_q30 = 64'sh000007FF;
      5'd20:   atan_q30 = 64'sh000003FF;
      5'd21:   atan_q30 = 64'sh000001FF;
      5'd22:   atan_q30 = 64'sh000000FF;
      5'd23:   atan_q30 = 64'sh0000007F;
      default: atan_q30 = 64'sd0;
    endcase
  endfunction

  // Convert a 30-fractional-bit value to 'frac' fractional bits, rounding to nearest.
  function automatic logic signed [63:0] rescale_q30(input logic signed [63:0] v, input int frac);
    if (frac >= 30) begin
      rescale_q30 = v <<< (frac - 30);
    end else begin
      rescale_q30 = (v + (64'sd1 <<< (29 - frac))) >>> (30 - frac);
    end
  endfunction

  // Signed add clamped to the range of a 'width'-bit two's complement word.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int width);
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (sum > max_v) begin
      sat_add = max_v;
    end else if (sum < min_v) begin
      sat_add = min_v;
    end else begin
      sat_add = sum;
    end
  endfunction

endpackage

// File: rtl/cordic_cos_ci_if.sv
// Request/response bundle of the CORDIC cosine custom instruction.
// The master (CPU side) issues start with operands; the slave returns done/result.
interface cordic_cos_ci_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic [1:0]       n;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, dataa, datab, n, input done, result);
  modport slave  (input start, dataa, datab, n, output done, result);
endinterface

// File: rtl/cordic_core.sv
// Iterative CORDIC rotator in rotation mode. 'load' seeds X=K, Y=0, Z=z_init;
// each 'step' performs iteration 'idx'. Words carry FI fractional bits, which
// the top sets two bits finer than the external format as guard bits.
module cordic_core
  import cordic_pkg::*;
#(
  parameter int IW = 34,
  parameter int FI = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [4:0]           idx,
  input  logic signed [IW-1:0] z_init,
  output logic signed [IW-1:0] x_out
);

  localparam logic signed [IW-1:0] K_I = IW'(rescale_q30(K_Q30, FI));

  logic signed [IW-1:0] x_q, x_d;
  logic signed [IW-1:0] y_q, y_d;
  logic signed [IW-1:0] z_q, z_d;
  logic signed [IW-1:0] atan_s;
  logic signed [IW-1:0] x_sh_s;
  logic signed [IW-1:0] y_sh_s;

  // One micro-rotation towards Z = 0, or a fresh seed on load.
  always_comb begin
    atan_s = IW'(rescale_q30(atan_q30(idx), FI));
    x_sh_s = x_q >>> idx;
    y_sh_s = y_q >>> idx;
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    if (load) begin
      x_d = K_I;
      y_d = {IW{1'b0}};
      z_d = z_init;
    end else if (step) begin
      if (!z_q[IW-1]) begin
        x_d = x_q - y_sh_s;
        y_d = y_q + x_sh_s;
        z_d = z_q - atan_s;
      end else begin
        x_d = x_q + y_sh_s;
        y_d = y_q - x_sh_s;
        z_d = z_q + atan_s;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
      z_d = z_q;
    end
  end

  // Rotator state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= {IW{1'b0}};
      y_q <= {IW{1'b0}};
      z_q <= {IW{1'b0}};
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign x_out = x_q;

endmodule

// File: rtl/cordic_cos_ci.sv
// CORDIC cosine custom instruction: result = cos(dataa), optionally added to
// datab or to an internal accumulator. Define CORDIC_ACC_EN to build the
// accumulator and modes 2 (acc += cos) and 3 (read-and-clear); otherwise
// those modes compute a plain cosine.
module cordic_cos_ci
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 22,
  parameter int ITER  = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  cordic_cos_ci_if.slave io
);

  localparam int IW = WIDTH + 2;
  localparam int FI = FRAC + 2;
  localparam logic signed [WIDTH-1:0] PI_F   = WIDTH'(rescale_q30(PI_Q30, FRAC));
  localparam logic signed [WIDTH-1:0] PI_2_F = WIDTH'(rescale_q30(PI_2_Q30, FRAC));
  localparam logic [4:0] LAST_IDX = 5'(ITER - 1);

  state_t                  state_q, state_d;
  mode_t                   mode_q, mode_d;
  mode_t                   mode_eff_s;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic signed [WIDTH-1:0] datab_q, datab_d;
  logic signed [WIDTH-1:0] result_q, result_d;
  logic                    negate_q, negate_d;
  logic                    done_q, done_d;
  logic [4:0]              idx_q, idx_d;
`ifdef CORDIC_ACC_EN
  logic signed [WIDTH-1:0] acc_q, acc_d;
`endif

  logic                    core_load_s;
  logic                    core_step_s;
  logic signed [WIDTH-1:0] x_clamp_s;
  logic signed [WIDTH-1:0] z_red_s;
  logic                    prep_negate_s;
  logic signed [IW-1:0]    z0_s;
  logic signed [IW-1:0]    core_x_s;
  logic signed [IW-1:0]    cos_full_s;
  logic signed [WIDTH-1:0] cos_s;

  // Requested mode; without the accumulator, modes 2 and 3 fall back to plain cos.
  always_comb begin
`ifdef CORDIC_ACC_EN
    mode_eff_s = mode_t'(io.n);
`else
    if (io.n[1]) begin
      mode_eff_s = MODE_COS;
    end else begin
      mode_eff_s = mode_t'(io.n);
    end
`endif
  end

  // Range reduction: clamp to [-pi, pi], fold into [-pi/2, pi/2] and remember the sign flip.
  always_comb begin
    if (x_q > PI_F) begin
      x_clamp_s = PI_F;
    end else if (x_q < -PI_F) begin
      x_clamp_s = -PI_F;
    end else begin
      x_clamp_s = x_q;
    end
    if (x_clamp_s > PI_2_F) begin
      z_red_s       = x_clamp_s - PI_F;
      prep_negate_s = 1'b1;
    end else if (x_clamp_s < -PI_2_F) begin
      z_red_s       = x_clamp_s + PI_F;
      prep_negate_s = 1'b1;
    end else begin
      z_red_s       = x_clamp_s;
      prep_negate_s = 1'b0;
    end
    z0_s = {z_red_s, 2'b00};
  end

  // Final cosine: undo the fold, then drop the guard bits with round-to-nearest.
  always_comb begin
    if (negate_q) begin
      cos_full_s = -core_x_s;
    end else begin
      cos_full_s = core_x_s;
    end
    cos_s = WIDTH'((cos_full_s + IW'(3'sd2)) >>> 2);
  end

  // Next-state, operand capture and result formation for the control FSM.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    x_d         = x_q;
    datab_d     = datab_q;
    negate_d    = negate_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    result_d    = result_q;
    core_load_s = 1'b0;
    core_step_s = 1'b0;
`ifdef CORDIC_ACC_EN
    acc_d       = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (io.start) begin
          x_d     = io.dataa;
          datab_d = io.datab;
          mode_d  = mode_eff_s;
          if (mode_eff_s == MODE_RDCLR) begin
            state_d = FINISH;
          end else begin
            state_d = PREP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PREP: begin
        core_load_s = clk_en;
        negate_d    = prep_negate_s;
        idx_d       = 5'd0;
        state_d     = ROTATE;
      end
      ROTATE: begin
        core_step_s = clk_en;
        if (idx_q == LAST_IDX) begin
          state_d = FINISH;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
        case (mode_q)
          MODE_COS: result_d = cos_s;
          MODE_ADD: result_d = WIDTH'(sat_add(64'(datab_q), 64'(cos_s), WIDTH));
`ifdef CORDIC_ACC_EN
          MODE_ACC: begin
            acc_d    = WIDTH'(sat_add(64'(acc_q), 64'(cos_s), WIDTH));
            result_d = acc_d;
          end
          MODE_RDCLR: begin
            result_d = acc_q;
            acc_d    = {WIDTH{1'b0}};
          end
`endif
          default: result_d = cos_s;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and registered outputs; clk_en low freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mode_q   <= MODE_COS;
      x_q      <= {WIDTH{1'b0}};
      datab_q  <= {WIDTH{1'b0}};
      negate_q <= 1'b0;
      idx_q    <= 5'd0;
      done_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
`ifdef CORDIC_ACC_EN
      acc_q    <= {WIDTH{1'b0}};
`endif
    end else if (clk_en) begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      x_q      <= x_d;
      datab_q  <= datab_d;
      negate_q <= negate_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      result_q <= result_d;
`ifdef CORDIC_ACC_EN
      acc_q    <= acc_d;
`endif
    end
  end

  cordic_core #(
    .IW(IW),
    .FI(FI)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (core_load_s),
    .step   (core_step_s),
    .idx    (idx_q),
    .z_init (z0_s),
    .x_out  (core_x_s)
  );

  assign io.done   = done_q;
  assign io.result = result_q;

endmodule

// File: doc/cordic_cos_ci.md
CORDIC_COS_CI -- requirements
Module: cordic_cos_ci

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width, two's complement fixed point.
REQ-002 Parameter FRAC, default 22: fractional bits; 1.0 = 2^FRAC.
REQ-003 Parameter ITER, default 16: CORDIC iterations, legal range 8..24.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 clk_en  in  1  when low, all state holds (full stall).
REQ-007 start  in  1  one-cycle request; sampled only while idle and clk_en high.
REQ-008 dataa  in  WIDTH  angle x in radians.
REQ-009 datab  in  WIDTH  addend (running sum from the caller).
REQ-010 n  in  2  mode: 0 cos, 1 datab+cos, 2 internal acc+=cos, 3 read-and-clear acc.
REQ-011 done  out  1  one-cycle pulse; result valid in that cycle.
REQ-012 result  out  WIDTH  output value; held until the next done.

Function
REQ-013 FSM states IDLE, PREP, ROTATE, FINISH; IDLE->PREP on start&clk_en; PREP->ROTATE; ROTATE->FINISH after ITER iterations; FINISH->IDLE with done=1.
REQ-014 Latency: done asserts exactly ITER+2 enabled cycles after the start edge; clk_en-low cycles add 1:1.
REQ-015 start during PREP/ROTATE/FINISH is ignored; no queueing.
REQ-016 PREP: clamp x to [-PI,+PI]; if x>PI/2 then z=x-PI, negate=1; if x<-PI/2 then z=x+PI, negate=1; else z=x, negate=0.
REQ-017 PREP initialises X=K (CORDIC gain reciprocal, 0.607252935*2^FRAC, rounded), Y=0, Z=z.
REQ-018 ROTATE iteration i: d=sign(Z); X-=d*(Y>>>i); Y+=d*(X>>>i); Z-=d*atan(2^-i); arithmetic shifts; 2 guard bits internally.
REQ-019 cos = negate ? -X : X; absolute error <= 2^-(ITER-2).
REQ-020 Mode 1: result = sat(datab + cos); datab captured at start.
REQ-021 Mode 2: acc = sat(acc + cos); result = new acc.
REQ-022 Mode 3: result = acc, acc cleared to 0; completes in 1 cycle (IDLE->FINISH), done one cycle after start.
REQ-023 Additions saturate to the signed WIDTH range, never wrap.
REQ-024 dataa/datab/n are captured at start; later changes have no effect.

Reset
REQ-025 Reset asserted: state=IDLE, done=0, result=0, acc=0, X/Y/Z=0, immediately and asynchronously.
REQ-026 Reset mid-operation aborts; no done pulse is produced for the aborted request.

Configuration
REQ-027 Macro CORDIC_ACC_EN defined: internal WIDTH-bit accumulator and modes 2/3 present.
REQ-028 Macro CORDIC_ACC_EN undefined: no accumulator storage; modes 2 and 3 behave as mode 0.

Structure
REQ-029 Package cordic_pkg: FSM state typedef, mode typedef, 24-entry atan table (Q2.30, rescaled to FRAC), K, PI and PI_2 constants, saturating-add function.
REQ-030 One sub-module cordic_core: iterative X/Y/Z rotator with load, step and index inputs; FSM and mode logic stay in cordic_cos_ci.

Verification (WIDTH=32, FRAC=22, ITER=16, tolerance 2^-14)
REQ-031 n=0, dataa=0x00000000 -> done at start+18 cycles, result ~0x00400000.
REQ-032 n=0, dataa=0x00C90FDB (pi) -> result ~0xFFC00000; dataa=0x006487ED (pi/2) -> result ~0x00000000.
REQ-033 n=1, datab=0x00400000, dataa=0 -> result ~0x00800000; datab=0x7FFFFFFF -> 0x7FFFFFFF (saturated).
REQ-034 n=2 three times with dataa=0, then n=3 -> result ~0x00C00000; next n=3 -> 0x00000000 (macro defined).
REQ-035 clk_en low for 5 cycles mid-ROTATE -> done at start+23 cycles, value unchanged; start pulsed while busy -> ignored.
REQ-036 reset low during ROTATE -> done stays 0, result 0x00000000; next request completes normally.
